text_console_engine: RTL and testbench
======================================

Name: text_console_engine

Overview:
- Single-clock, parametrised successor to the fixed VGA console path. It combines timing generation, an on-chip text buffer, font fetch and attribute colouring in one block.
- Host writes character/attribute words through a valid/ready port. The block streams aligned sync, DE and RGBI pixels.
- Adds a hardware clear engine, per-cell 16-colour attributes and a blinking underline cursor.
- Sits between the host bus and the VGA pins. The font ROM lives outside the block.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
- GLYPH_H, 16, glyph lines per cell (glyph width fixed at 8)
- BLINK_FRAMES, 30, frames per cursor blink half-period
- Derived: COLS=H_ACTIVE/8, ROWS=V_ACTIVE/GLYPH_H, CELLS=COLS*ROWS, AW=clog2(CELLS)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted when valid&ready
- wr_addr  in  AW  cell index (row*COLS+col)
- wr_data  in  16  [7:0] char code, [11:8] fg index, [15:12] bg index
- clr_req  in  1  pulse: start a buffer clear
- font_addr  out  8+clog2(GLYPH_H)  {char, glyph line}
- font_data  in  8  glyph row, MSB = leftmost; valid 1 clk after font_addr
- cursor_en  in  1  cursor enable
- cursor_pos  in  AW  cursor cell index
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync
- de  out  1  display enable
- r, g, b, i  out  1 each  colour index bits 0, 1, 2 and intensity bit 3
- frame_start  out  1  one-cycle pulse at h=0, v=0 (stage 0)

Behaviour:
Reset:
- All outputs register to their inactive values: sync = ~SYNC_POL, de = 0, r/g/b/i = 0, frame_start = 0.
- Counters and blink state go to 0.
- The clear engine starts automatically and wr_ready = 0.

Timing counters:
- h_cnt runs 0..H_TOTAL-1. v_cnt increments on h wrap and runs 0..V_TOTAL-1.
- Active region: h < H_ACTIVE and v < V_ACTIVE.
- Sync asserts for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. Vertical sync is analogous.

Pixel pipeline (fixed latency 4; sync and de are delayed 4 clocks to stay aligned):
- S0: counters; compute cell = (v/GLYPH_H)*COLS + h/8, glyph line = v%GLYPH_H, bit = h%8.
- S1: registered text RAM read.
- S2: font_addr driven.
- S3: font_data captured.
- S4: pixel = font_data[7-bit]. Cursor XOR applies when cursor_en, cell == cursor_pos, glyph line >= GLYPH_H-2 and blink phase = 1. Colour index = pixel ? fg : bg. Outputs are zeroed when delayed de = 0.

Blink:
- A frame counter increments on frame_start.
- At BLINK_FRAMES-1 it wraps to 0 and toggles the phase (initial phase 0).

Clear FSM:
- States: IDLE, CLEAR.
- IDLE -> CLEAR on rst release or on clr_req. Each CLEAR cycle writes 0x0720 (space, fg 7, bg 0) to address clr_ptr++. It takes CELLS cycles, then returns to IDLE.
- wr_ready = (state == IDLE). Host writes are never dropped; they wait for IDLE.
- clr_req during CLEAR is ignored (no restart).
- Reset mid-clear restarts the clear from 0.

Host write:
- A write with valid&ready is written to RAM in that cycle.
- The display reads the new value from the next RAM read onward. Read and write ports are separate, so there is no display stall.
- wr_addr >= CELLS is accepted and discarded.

Write/read collision:
- Same address in the same cycle: the read returns old data.

Decomposition:
- Package console_pkg:
  - default timing constants for 640x480
  - CLEAR_WORD = 16'h0720
  - attribute field positions
  - pipeline latency constant PIPE_LAT = 4
- Sub-module console_timing: counters, sync, active, frame_start; reusable on its own.
- The text RAM is inferred inside the top module.

Test Plan:
- Reset then release -> wr_ready low for exactly 2400 clocks, then high. RAM reads back 0x0720 at cells 0 and 2399.
- Free-run one frame -> h_sync low for 96 clocks starting at h = 656. Line length 800, frame 525 lines. frame_start once per 420000 clocks.
- Write addr 0 data 0x1F41, font model 'A' line 0 = 0x18 -> at v=0, de pixels 3 and 4 give index F (r=g=b=i=1); other pixels give index 1 (r=1 only). Output appears 4 clocks after h.
- cursor_en=1, cursor_pos=81 -> lines 30-31, cols 8-15: pixels inverted in frames 30-59, normal in frames 0-29 and 60-89.
- Assert clr_req while wr_valid is held high with addr 5 -> write accepted only on the first cycle after CLEAR ends. Cell 5 holds the host data, not 0x0720.
- Assert rst at clear count 1000 -> the clear restarts and lasts a full 2400 clocks after release.

Source files
------------

// File: rtl/console_pkg.sv
// console_pkg: shared timing defaults, attribute layout and clear-engine types for the text console
package console_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [15:0] CLEAR_WORD = 16'h0720;

    localparam int CHAR_LSB = 0;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 12;

    localparam int PIPE_LAT = 4;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

endpackage

// File: rtl/console_timing.sv
// console_timing: raster counters with sync, active-region and frame-start generation
module console_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          h_sync,
    output logic          v_sync,
    output logic          active,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic h_last;
    logic v_last;

    // Wrap detection for both counters
    always_comb begin
        h_last = int'(h_cnt) == H_TOTAL - 1;
        v_last = int'(v_cnt) == V_TOTAL - 1;
    end

    // Counters advance every clock; frame_start is registered so it coincides with (0,0) yet stays low out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_last ? '0 : h_cnt + 1'b1;
            v_cnt       <= h_last ? (v_last ? '0 : v_cnt + 1'b1) : v_cnt;
            frame_start <= h_last && v_last;
        end
    end

    // Region decode with sync polarity applied
    always_comb begin
        active = int'(h_cnt) < H_ACTIVE && int'(v_cnt) < V_ACTIVE;
        h_sync = (int'(h_cnt) >= H_ACTIVE + H_FP && int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC) ~^ SYNC_POL;
        v_sync = (int'(v_cnt) >= V_ACTIVE + V_FP && int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC) ~^ SYNC_POL;
    end

endmodule

// File: rtl/text_console_engine.sv
// text_console_engine: text buffer, clear engine, font fetch and attribute colouring driving VGA pins
module text_console_engine
    import console_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter bit SYNC_POL     = 1'b0,
    parameter int GLYPH_H      = 16,
    parameter int BLINK_FRAMES = 30,
    localparam int COLS  = H_ACTIVE / 8,
    localparam int CELLS = COLS * (V_ACTIVE / GLYPH_H),
    localparam int AW    = $clog2(CELLS),
    localparam int GLW   = $clog2(GLYPH_H),
    localparam int FAW   = 8 + GLW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [AW-1:0]  wr_addr,
    input  logic [15:0]    wr_data,
    input  logic           clr_req,
    output logic [FAW-1:0] font_addr,
    input  logic [7:0]     font_data,
    input  logic           cursor_en,
    input  logic [AW-1:0]  cursor_pos,
    output logic           h_sync,
    output logic           v_sync,
    output logic           de,
    output logic           r,
    output logic           g,
    output logic           b,
    output logic           i,
    output logic           frame_start
);

    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [2:0] SY_IDLE = {!SYNC_POL, !SYNC_POL, 1'b0};

    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic           hs0, vs0, act0;
    logic [AW-1:0]  cell0;
    logic [GLW-1:0] gl0, gl1;
    logic [2:0]     bit0, bit1, bit2, bit3;
    logic           cur0, cur1, cur2, cur3;
    logic [3:0]     fg2, bg2, fg3, bg3;
    logic [15:0]    rd_word;
    logic [2:0]     sy_pipe [1:PIPE_LAT-1];
    logic [BW-1:0]  blink_cnt;
    logic           blink_phase;
    logic           pix;
    logic [3:0]     idx;

    clr_state_t     state, state_nx;
    logic [AW-1:0]  clr_ptr;
    logic           clr_last;
    logic           ram_we;
    logic [AW-1:0]  ram_waddr;
    logic [15:0]    ram_wdata;
    logic [15:0]    ram [CELLS];

    console_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL)
    ) u_timing (
        .clk(clk),
        .rst(rst),
        .h_cnt(h_cnt),
        .v_cnt(v_cnt),
        .h_sync(hs0),
        .v_sync(vs0),
        .active(act0),
        .frame_start(frame_start)
    );

    // Stage 0: map raster position to cell, glyph line and bit; blanking reads cell 0 to keep the index in range
    always_comb begin
        cell0 = act0 ? AW'((int'(v_cnt) / GLYPH_H) * COLS + int'(h_cnt) / 8) : '0;
        gl0   = GLW'(int'(v_cnt) % GLYPH_H);
        bit0  = h_cnt[2:0];
        cur0  = act0 && cursor_en && cell0 == cursor_pos && int'(gl0) >= GLYPH_H - 2;
    end

    // Clear state and pointer; reset lands directly in CLEAR so the buffer is wiped as soon as reset drops
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nx;
            clr_ptr <= (state == CLEAR && !clr_last) ? clr_ptr + 1'b1 : '0;
        end
    end

    // Next state, host handshake and the shared write-port mux (clear has priority by holding ready low)
    always_comb begin
        clr_last  = int'(clr_ptr) == CELLS - 1;
        state_nx  = (state == IDLE) ? (clr_req ? CLEAR : IDLE) : (clr_last ? IDLE : CLEAR);
        wr_ready  = state == IDLE;
        ram_we    = !rst && (state == CLEAR || (wr_valid && wr_ready && int'(wr_addr) < CELLS));
        ram_waddr = (state == CLEAR) ? clr_ptr : wr_addr;
        ram_wdata = (state == CLEAR) ? CLEAR_WORD : wr_data;
    end

    // Text buffer: one write port and one registered read port; a same-address read returns the old word
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        rd_word <= ram[cell0];
    end

    // Per-pixel side data travelling alongside the RAM read and font fetch
    always_ff @(posedge clk) begin
        gl1       <= gl0;
        bit1      <= bit0;
        cur1      <= cur0;
        font_addr <= {rd_word[CHAR_LSB +: 8], gl1};
        fg2       <= rd_word[FG_LSB +: 4];
        bg2       <= rd_word[BG_LSB +: 4];
        bit2      <= bit1;
        cur2      <= cur1;
        fg3       <= fg2;
        bg3       <= bg2;
        bit3      <= bit2;
        cur3      <= cur2;
    end

    // Sync and DE delay line matching the pixel latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < PIPE_LAT; k++) sy_pipe[k] <= SY_IDLE;
        end else begin
            sy_pipe[1] <= {hs0, vs0, act0};
            for (int k = 2; k < PIPE_LAT; k++) sy_pipe[k] <= sy_pipe[k-1];
        end
    end

    // Cursor blink: frame counter wraps every BLINK_FRAMES frames and flips the phase
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            blink_cnt   <= (int'(blink_cnt) == BLINK_FRAMES - 1) ? '0 : blink_cnt + 1'b1;
            blink_phase <= (int'(blink_cnt) == BLINK_FRAMES - 1) ? !blink_phase : blink_phase;
        end
    end

    // Stage 4 pixel: glyph bit with cursor inversion, then attribute colour lookup
    always_comb begin
        pix = font_data[3'd7 - bit3] ^ (cur3 && blink_phase);
        idx = pix ? fg3 : bg3;
    end

    // Output register; colour forced to zero outside the active region
    always_ff @(posedge clk) begin
        if (rst) begin
            {h_sync, v_sync, de} <= SY_IDLE;
            {i, b, g, r}         <= 4'h0;
        end else begin
            {h_sync, v_sync, de} <= sy_pipe[PIPE_LAT-1];
            {i, b, g, r}         <= sy_pipe[PIPE_LAT-1][0] ? idx : 4'h0;
        end
    end

endmodule

// File: tb/tb_text_console_engine.sv
// tb_text_console_engine: randomized check of the console against a raster-level reference model
module tb_text_console_engine;

    localparam int HA = 40, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 12, VFP = 2, VS = 2, VBP = 2;
    localparam int GH = 4, BF = 2;
    localparam bit SP = 1'b0;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int COLS = HA / 8;
    localparam int CELLS = COLS * (VA / GH);
    localparam int AW = $clog2(CELLS);
    localparam int GW = $clog2(GH);

    typedef struct {
        logic [6:0] v;
        bit         full;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          clr_req = 1'b0;
    logic          cursor_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] cursor_pos = '0;
    logic [15:0]   wr_data = '0;
    logic [7+GW:0] font_addr;
    logic [7:0]    font_data;
    logic          wr_ready, h_sync, v_sync, de, r, g, b, i, frame_start;

    logic [7:0]    rom [256*GH];
    logic [15:0]   mem [CELLS];
    bit            known [CELLS];
    exp_t          q [$];
    int            n, clr_k, lo;
    bit            clr_on, acc;
    int            total = 0;
    int            bad = 0;

    text_console_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(SP), .GLYPH_H(GH), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_en(cursor_en), .cursor_pos(cursor_pos),
        .h_sync(h_sync), .v_sync(v_sync), .de(de),
        .r(r), .g(g), .b(b), .i(i),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) font_data <= rom[font_addr];

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d after reset)", tag, obs, exp, n);
        end
    endtask

    task automatic sample();
        exp_t e;
        int pos, h, v, f, c, gl, bt;
        logic [15:0] w;
        logic [3:0] idx;
        bit pix, act, hs_in, vs_in;
        acc = 0;
        if (rst) begin
            n = 0;
            clr_on = 1;
            clr_k = 0;
            q.delete();
            repeat (4) q.push_back('{{!SP, !SP, 5'b0}, 1'b1});
            return;
        end
        e = q.pop_front();
        if (e.full) check("pixel", {h_sync, v_sync, de, r, g, b, i}, e.v);
        else check("sync", {h_sync, v_sync, de}, e.v[6:4]);
        check("wr_ready", wr_ready, !clr_on);
        check("frame_start", frame_start, n > 0 && n % FT == 0);
        pos = n % FT;
        h = pos % HT;
        v = pos / HT;
        f = n / FT;
        act = h < HA && v < VA;
        hs_in = h >= HA + HFP && h < HA + HFP + HS;
        vs_in = v >= VA + VFP && v < VA + VFP + VS;
        e.v = {hs_in ? SP : !SP, vs_in ? SP : !SP, act, 4'b0};
        e.full = 1;
        if (act) begin
            c = (v / GH) * COLS + h / 8;
            gl = v % GH;
            bt = h % 8;
            w = mem[c];
            e.full = known[c];
            pix = rom[w[7:0] * GH + gl][7 - bt];
            if (cursor_en && c == cursor_pos && gl >= GH - 2 && (f / BF) % 2 == 1) pix = !pix;
            idx = pix ? w[11:8] : w[15:12];
            e.v[3:0] = {idx[0], idx[1], idx[2], idx[3]};
        end
        q.push_back(e);
        if (clr_on) begin
            mem[clr_k] = 16'h0720;
            known[clr_k] = 1;
            clr_k++;
            if (clr_k == CELLS) clr_on = 0;
        end else begin
            if (wr_valid) begin
                acc = 1;
                if (wr_addr < CELLS) begin
                    mem[wr_addr] = wr_data;
                    known[wr_addr] = 1;
                end
            end
            if (clr_req) begin
                clr_on = 1;
                clr_k = 0;
            end
        end
        n++;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cycles, input bit rnd);
        for (int k = 0; k < cycles; k++) begin
            if (rnd) begin
                if (acc) wr_valid = 0;
                if (!wr_valid && $urandom_range(3) == 0) begin
                    wr_valid = 1;
                    wr_addr = AW'($urandom_range(CELLS));
                    wr_data = 16'($urandom);
                end
                clr_req = $urandom_range(400) == 0;
                if ($urandom_range(150) == 0) begin
                    cursor_en = 1'($urandom);
                    cursor_pos = AW'($urandom_range(CELLS - 1));
                end
            end
            step();
        end
        wr_valid = 0;
        clr_req = 0;
    endtask

    task automatic wait_ready(input string tag, input int want);
        lo = 0;
        while (!wr_ready && lo < 4 * CELLS) begin
            step();
            lo++;
        end
        check(tag, lo, want);
    endtask

    initial begin
        for (int k = 0; k < 256 * GH; k++) rom[k] = 8'($urandom);
        rom[8'h41 * GH] = 8'h18;
        for (int k = 0; k < CELLS; k++) known[k] = 0;
        rst = 1;
        repeat (3) step();
        rst = 0;
        wait_ready("boot_clear_len", CELLS);

        wr_valid = 1;
        wr_addr = '0;
        wr_data = 16'h1F41;
        step();
        wr_valid = 0;
        run(2 * FT, 0);

        run(3 * FT, 1);
        run(CELLS + 2, 0);

        clr_req = 1;
        step();
        clr_req = 0;
        wr_valid = 1;
        wr_addr = AW'(5);
        wr_data = 16'hA5C3;
        lo = 0;
        while (!acc && lo < 4 * CELLS) begin
            clr_req = lo == 5;
            step();
            lo++;
        end
        clr_req = 0;
        wr_valid = 0;
        check("held_write_wait", lo, CELLS + 1);
        run(FT, 0);

        clr_req = 1;
        step();
        clr_req = 0;
        run(7, 0);
        rst = 1;
        repeat (2) step();
        rst = 0;
        wait_ready("restart_clear_len", CELLS);

        cursor_en = 1;
        cursor_pos = AW'(COLS + 1);
        run(6 * FT, 0);
        run(2 * FT, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
